// File: rtl/chunked_alu.sv
// ============================================================================
//  Module      : chunked_alu
//  Description : Multi-cycle ALU (AND/OR/ADD/SUB/SLT) with a CHUNK-bit-per-
//                clock carry chain and valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_alu #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("chunked_alu: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARITH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_cy;
    logic              r_slt;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_overflow;
    logic              r_err;

    logic              w_accept;
    logic              w_is_arith;
    logic              w_is_sub;
    logic              w_is_illegal;
    logic              w_last;
    logic [WIDTH-1:0]  w_logic_res;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_sum;
    logic              w_msb;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_arith_res;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign err       = r_err;

    assign w_accept     = in_valid && (r_state == S_IDLE);
    assign w_is_arith   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    assign w_is_sub     = (op == OP_SUB) || (op == OP_SLT);
    assign w_is_illegal = !w_is_arith && (op != OP_AND) && (op != OP_OR);
    assign w_last       = (r_idx == LAST_IDX);

    always_comb begin
        w_logic_res = '0;
        case (op)
            OP_AND:  w_logic_res = a & b;
            OP_OR:   w_logic_res = a | b;
            default: w_logic_res = '0;
        endcase
    end

    // One CHUNK-wide slice of the carry chain per ARITH cycle
    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK+1)'(r_cy);
    assign w_msb     = w_sum[CHUNK-1];
    assign w_ovf     = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_msb != r_a[WIDTH-1]);

    always_comb begin
        w_arith_res = r_result;
        w_arith_res[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
        // SLT: sign of (a-b) corrected by overflow gives the signed compare
        if (r_slt && w_last) begin
            w_arith_res = {{(WIDTH-1){1'b0}}, w_msb ^ w_ovf};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_is_arith ? S_ARITH : S_DONE;
            S_ARITH: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_cy       <= 1'b0;
            r_slt      <= 1'b0;
            r_idx      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_arith) begin
                            r_a   <= a;
                            r_b   <= w_is_sub ? ~b : b;
                            r_cy  <= w_is_sub;
                            r_slt <= (op == OP_SLT);
                            r_idx <= '0;
                        end else begin
                            r_result   <= w_logic_res;
                            r_zero     <= (w_logic_res == '0);
                            r_carry    <= 1'b0;
                            r_overflow <= 1'b0;
                            r_err      <= w_is_illegal;
                        end
                    end
                end
                S_ARITH: begin
                    r_result <= w_arith_res;
                    r_cy     <= w_sum[CHUNK];
                    r_idx    <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_idx      <= '0;
                        r_zero     <= (w_arith_res == '0);
                        r_carry    <= r_slt ? 1'b0 : w_sum[CHUNK];
                        r_overflow <= w_ovf;
                        r_err      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chunked_alu.sv
// ============================================================================
//  Module      : tb_chunked_alu
//  Description : Scoreboard testbench for chunked_alu (WIDTH=32, CHUNK=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_alu;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        err;

    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    chunked_alu #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        logic [32:0] s;
        r = '0;
        s = '0;
        case (o)
            3'b000: r.res = x & y;
            3'b001: r.res = x | y;
            3'b010: begin
                s     = {1'b0, x} + {1'b0, y};
                r.res = s[31:0];
                r.c   = s[32];
                r.v   = (x[31] == y[31]) && (s[31] != x[31]);
            end
            3'b110: begin
                s     = {1'b0, x} + {1'b0, ~y} + 33'd1;
                r.res = s[31:0];
                r.c   = s[32];
                r.v   = (x[31] != y[31]) && (s[31] != x[31]);
            end
            3'b111: begin
                s     = {1'b0, x} + {1'b0, ~y} + 33'd1;
                r.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                r.v   = (x[31] != y[31]) && (s[31] != x[31]);
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    // Scoreboard: compare on the cycle whose closing edge completes the output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",   64'(result),   64'(e.res));
                check("zero",     64'(zero),     64'(e.z));
                check("carry",    64'(carry),    64'(e.c));
                check("overflow", 64'(overflow), 64'(e.v));
                check("err",      64'(err),      64'(e.e));
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        int lat;
        lat = (o == 3'b010 || o == 3'b110 || o == 3'b111) ? 5 : 1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        sb.push_back(model(o, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom);
        n  = 1;
        while (!out_valid && n < 40) begin
            check("in_ready_busy", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("in_ready_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [2:0] legal_ops [5];
        int n;
        legal_ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_flags",     64'({zero, carry, overflow, err}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(3'b000, 32'h0000A5A5, 32'h00005A5A);
        send(3'b001, 32'h0000A5A5, 32'h00005A5A);
        send(3'b010, 32'hFFFFFFFF, 32'h00000001);
        send(3'b010, 32'h7FFFFFFF, 32'h00000001);
        send(3'b110, 32'h80000000, 32'h00000001);
        send(3'b110, 32'h00000003, 32'h00000005);
        send(3'b111, 32'hFFFFFFFF, 32'h00000001);
        send(3'b111, 32'h7FFFFFFF, 32'h80000000);
        send(3'b111, 32'h00000005, 32'h00000005);

        // Backpressure with a pending request held during the stall
        out_ready = 1'b0;
        send(3'b010, 32'h12345678, 32'h11111111);
        in_valid = 1'b1;
        op = 3'b110;
        a  = 32'd100;
        b  = 32'd1;
        for (int i = 0; i < 10; i++) begin
            check("hold_result",    64'(result),    64'h23456789);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready",  64'(in_ready),  64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        sb.push_back(model(3'b110, 32'd100, 32'd1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pending_accepted", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("pending_done", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Reset during the second ARITH cycle
        check("abort_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op = 3'b010;
        a  = 32'hFFFFFFFF;
        b  = 32'h00000001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_result",    64'(result),    64'd0);
        check("abort_flags",     64'({zero, carry, overflow, err}), 64'd0);
        send(3'b010, 32'd2, 32'd3);
        send(3'b011, 32'h12345678, 32'h9ABCDEF0);
        send(3'b100, 32'h1, 32'h1);

        for (int i = 0; i < 16; i++) begin
            send(legal_ops[$urandom_range(0, 4)], $urandom, $urandom);
        end
        send(3'b111, 32'h80000000, 32'h7FFFFFFF);
        send(3'b110, 32'h0, 32'h0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
